// File: rtl/dcm_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dcm_seq_pkg : state encoding and sizing helpers for the DCM        |
// |               reset sequencer                                      |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package dcm_seq_pkg;

  localparam logic [2:0] c_ST_RESET_DCM = 3'd0;
  localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] c_ST_STABILIZE = 3'd2;
  localparam logic [2:0] c_ST_RUN       = 3'd3;
  localparam logic [2:0] c_ST_FAULT     = 3'd4;

  typedef enum logic [2:0] {
    ST_RESET_DCM = c_ST_RESET_DCM,
    ST_WAIT_LOCK = c_ST_WAIT_LOCK,
    ST_STABILIZE = c_ST_STABILIZE,
    ST_RUN       = c_ST_RUN,
    ST_FAULT     = c_ST_FAULT
  } seq_state_e;

  localparam int c_RETRY_W = 3;
  localparam int c_LOSS_W  = 8;

  // One counter serves every phase, so it is sized for the longest load value.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_2ff : two-flop single-bit synchronizer, clears to 0 on reset  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/dcm_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dcm_reset_sequencer : pulses DCM reset, waits for a stable lock    |
// |   with timeout/retry, then releases downstream reset.              |
// | Optional: DCM_SEQ_LOSS_CNT_EN adds LOSS_CNT / LOSS_PULSE outputs.  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module dcm_reset_sequencer
  import dcm_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 3,
  parameter int LOCK_TIMEOUT    = 2000000,
  parameter int STABLE_CYCLES   = 1024,
  parameter int MAX_RETRIES     = 7
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOCKED,
  output logic                 DCM_RST,
  output logic                 SYS_RST_N,
  output logic                 READY,
  output logic                 FAULT,
  output logic [c_RETRY_W-1:0] RETRY_CNT
`ifdef DCM_SEQ_LOSS_CNT_EN
  ,
  output logic [c_LOSS_W-1:0]  LOSS_CNT,
  output logic                 LOSS_PULSE
`endif
);

  localparam int                   c_CNT_W     = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [c_CNT_W-1:0]   c_HOLD_LOAD = c_CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]   c_WAIT_LOAD = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0]   c_STAB_LOAD = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRIES);

  seq_state_e           state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_RETRY_W-1:0] retry_q, retry_d;
  logic                 dcm_rst_q;
  logic                 sys_rst_n_q;
  logic                 fault_q;
  logic                 w_lock_s;
  logic                 w_cnt_zero;
  logic                 w_fail;

  sync_2ff u_lock_sync (
    .clk_i  (CLK),
    .rst_ni (RST),
    .d_i    (LOCKED),
    .q_o    (w_lock_s)
  );

  assign w_cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    w_fail  = 1'b0;
    case (state_q)
      ST_RESET_DCM: begin
        if (w_cnt_zero) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = c_WAIT_LOAD;
        end else begin
          cnt_d = cnt_q - c_CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as a lock.
        if (w_lock_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = c_STAB_LOAD;
        end else if (w_cnt_zero) begin
          w_fail = 1'b1;
        end else begin
          cnt_d = cnt_q - c_CNT_W'(1);
        end
      end
      ST_STABILIZE: begin
        if (!w_lock_s) begin
          w_fail = 1'b1;
        end else if (w_cnt_zero) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q - c_CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          state_d = ST_RESET_DCM;
          cnt_d   = c_HOLD_LOAD;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RESET_DCM;
        cnt_d   = c_HOLD_LOAD;
      end
    endcase

    if (w_fail) begin
      if (retry_q == c_MAX_RETRY) begin
        state_d = ST_FAULT;
      end else begin
        retry_d = retry_q + c_RETRY_W'(1);
        state_d = ST_RESET_DCM;
        cnt_d   = c_HOLD_LOAD;
      end
    end
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_RESET_DCM;
      cnt_q       <= c_HOLD_LOAD;
      retry_q     <= '0;
      dcm_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      dcm_rst_q   <= (state_d == ST_RESET_DCM) || (state_d == ST_FAULT);
      sys_rst_n_q <= (state_q == ST_RUN) && (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign DCM_RST   = dcm_rst_q;
  assign SYS_RST_N = sys_rst_n_q;
  assign READY     = sys_rst_n_q;
  assign FAULT     = fault_q;
  assign RETRY_CNT = retry_q;

`ifdef DCM_SEQ_LOSS_CNT_EN
  logic [c_LOSS_W-1:0] loss_cnt_q;
  logic                loss_pulse_q;
  logic                w_loss_evt;

  assign w_loss_evt = (state_q == ST_RUN) && !w_lock_s;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      loss_cnt_q   <= '0;
      loss_pulse_q <= 1'b0;
    end else begin
      loss_pulse_q <= w_loss_evt;
      if (w_loss_evt && (loss_cnt_q != {c_LOSS_W{1'b1}})) begin
        loss_cnt_q <= loss_cnt_q + c_LOSS_W'(1);
      end
    end
  end

  assign LOSS_CNT   = loss_cnt_q;
  assign LOSS_PULSE = loss_pulse_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcm_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dcm_reset_sequencer : vector table, directed corner sequences   |
// |   and randomized LOCKED/RST against a behavioural model.           |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_dcm_reset_sequencer;

  localparam int RST_HOLD = 3;
  localparam int TIMEOUT  = 20;
  localparam int STABLE   = 8;
  localparam int MAXR     = 2;

  logic       CLK;
  logic       RST;
  logic       LOCKED;
  logic       DCM_RST;
  logic       SYS_RST_N;
  logic       READY;
  logic       FAULT;
  logic [2:0] RETRY_CNT;
`ifdef DCM_SEQ_LOSS_CNT_EN
  logic [7:0] LOSS_CNT;
  logic       LOSS_PULSE;
`endif

  dcm_reset_sequencer #(
    .RST_HOLD_CYCLES (RST_HOLD),
    .LOCK_TIMEOUT    (TIMEOUT),
    .STABLE_CYCLES   (STABLE),
    .MAX_RETRIES     (MAXR)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LOCKED    (LOCKED),
    .DCM_RST   (DCM_RST),
    .SYS_RST_N (SYS_RST_N),
    .READY     (READY),
    .FAULT     (FAULT),
    .RETRY_CNT (RETRY_CNT)
`ifdef DCM_SEQ_LOSS_CNT_EN
    ,
    .LOSS_CNT  (LOSS_CNT),
    .LOSS_PULSE(LOSS_PULSE)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return DCM_RST;
      1:       return READY;
      2:       return SYS_RST_N;
      default: return FAULT;
    endcase
  endfunction

  // Steps until the selected output reaches val or the bound expires; the final compare reports expiry.
  task automatic wait_sig(input int sel, input logic val, input int bound, input string nm, output int n);
    n = 0;
    while (sig(sel) !== val && n < bound) begin
      step();
      n++;
    end
    chk(nm, sig(sel), val);
  endtask

  // Behavioural model: phases with elapsed-cycle counters, LOCKED seen two samples late.
  typedef enum {M_HOLD, M_WAIT, M_STAB, M_RUN, M_FAULT} mph_e;
  mph_e m_ph    = M_HOLD;
  int   m_age   = 0;
  int   m_retry = 0;
  int   m_loss  = 0;
  logic m_pulse = 1'b0;
  logic m_h0    = 1'b0;
  logic m_h1    = 1'b0;
  bit   m_valid = 1'b0;

  task automatic model_fail();
    if (m_retry == MAXR) begin
      m_ph = M_FAULT;
    end else begin
      m_retry++;
      m_ph  = M_HOLD;
      m_age = 1;
    end
  endtask

  task automatic model_step(input logic r, input logic lk);
    logic ls;
    if (!r) begin
      m_ph = M_HOLD; m_age = 1; m_retry = 0; m_loss = 0; m_pulse = 1'b0;
      m_h0 = 1'b0; m_h1 = 1'b0; m_valid = 1'b1;
    end else begin
      ls = m_h1; m_h1 = m_h0; m_h0 = lk;
      m_pulse = 1'b0;
      case (m_ph)
        M_HOLD: if (m_age >= RST_HOLD) begin m_ph = M_WAIT; m_age = 1; end else m_age++;
        M_WAIT: begin
          if (ls) begin m_ph = M_STAB; m_age = 1; end
          else if (m_age >= TIMEOUT) model_fail();
          else m_age++;
        end
        M_STAB: begin
          if (!ls) model_fail();
          else if (m_age >= STABLE) begin m_ph = M_RUN; m_age = 1; m_retry = 0; end
          else m_age++;
        end
        M_RUN: begin
          if (!ls) begin
            m_ph = M_HOLD; m_age = 1; m_pulse = 1'b1;
            m_loss = (m_loss >= 255) ? 255 : m_loss + 1;
          end else m_age++;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    logic m_dcm, m_sys;
    forever begin
      @(posedge CLK);
      model_step(RST, LOCKED);
      @(negedge CLK);
      if (m_valid) begin
        m_dcm = (m_ph == M_HOLD) || (m_ph == M_FAULT);
        m_sys = (m_ph == M_RUN) && (m_age >= 2);
        chk("model", {DCM_RST, SYS_RST_N, READY, FAULT, RETRY_CNT},
            {m_dcm, m_sys, m_sys, (m_ph == M_FAULT), 3'(m_retry)});
`ifdef DCM_SEQ_LOSS_CNT_EN
        chk("model_loss", {LOSS_PULSE, LOSS_CNT}, {m_pulse, 8'(m_loss)});
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       rst;
    logic       locked;
    logic       dcm;
    logic       sys;
    logic       fault;
    logic [2:0] retry;
  } vec_t;

  vec_t tbl[8];
  int   n;
  int   rises;
  int   run;
  logic prev;

  initial begin
    // Reset and first hold/wait cycles: DCM_RST stays high for the reset edge plus two more.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};

    RST = 1'b0;
    LOCKED = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      RST = tbl[i].rst;
      LOCKED = tbl[i].locked;
      step();
      chk($sformatf("vec%0d", i), {DCM_RST, SYS_RST_N, READY, FAULT, RETRY_CNT},
          {tbl[i].dcm, tbl[i].sys, tbl[i].sys, tbl[i].fault, tbl[i].retry});
    end

    // Normal lock
    RST = 1'b0; step(); RST = 1'b1;
    n = 0;
    while (DCM_RST === 1'b1 && n < 10) begin n++; step(); end
    chk("dcm_hold_len", n, RST_HOLD);
    repeat (5) step();
    LOCKED = 1'b1;
    step();  // first edge that samples LOCKED high
    wait_sig(2, 1'b1, 40, "lock_sys_rise", n);
    chk("lock_latency", n, 2 + STABLE + 1);
    chk("lock_ready", READY, 1'b1);
    chk("lock_dcm", DCM_RST, 1'b0);
    chk("lock_retry", RETRY_CNT, 3'd0);

    // Lock loss in RUN
    LOCKED = 1'b0;
    n = 0;
    while (SYS_RST_N === 1'b1 && n < 10) begin step(); n++; end
    chk("loss_latency", n, 3);
    chk("loss_dcm", DCM_RST, 1'b1);
    chk("loss_ready", READY, 1'b0);
    chk("loss_retry", RETRY_CNT, 3'd0);
`ifdef DCM_SEQ_LOSS_CNT_EN
    chk("loss_cnt", LOSS_CNT, 8'd1);
    chk("loss_pulse", LOSS_PULSE, 1'b1);
    step();
    chk("loss_pulse_end", LOSS_PULSE, 1'b0);
`endif

    // Mid-run reset
    LOCKED = 1'b1;
    wait_sig(1, 1'b1, 60, "relock_ready", n);
    RST = 1'b0; step(); RST = 1'b1;
    chk("mid_rst_out", {DCM_RST, SYS_RST_N, READY, FAULT, RETRY_CNT}, {1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
`ifdef DCM_SEQ_LOSS_CNT_EN
    chk("mid_rst_loss", LOSS_CNT, 8'd0);
`endif

    // Timeout retries into FAULT
    LOCKED = 1'b0;
    RST = 1'b0; step(); RST = 1'b1;
    n = 0; rises = 0; prev = DCM_RST;
    while (FAULT !== 1'b1 && n < 200) begin
      step(); n++;
      if (DCM_RST === 1'b1 && prev === 1'b0 && FAULT === 1'b0) begin
        rises++;
        chk($sformatf("retry_at_pulse%0d", rises), RETRY_CNT, rises);
      end
      prev = DCM_RST;
    end
    chk("fault_time", n, (MAXR + 1) * (RST_HOLD + TIMEOUT));
    chk("dcm_pulses", rises + 1, MAXR + 1);
    chk("fault_state", {DCM_RST, SYS_RST_N, FAULT, RETRY_CNT}, {1'b1, 1'b0, 1'b1, 3'(MAXR)});
    LOCKED = 1'b1;
    repeat (30) step();
    chk("fault_sticky", {DCM_RST, READY, FAULT, RETRY_CNT}, {1'b1, 1'b0, 1'b1, 3'(MAXR)});
    LOCKED = 1'b0;
    RST = 1'b0; step(); RST = 1'b1;
    chk("fault_clear", {FAULT, RETRY_CNT, DCM_RST}, {1'b0, 3'd0, 1'b1});

    // Glitch in STABILIZE
    wait_sig(0, 1'b0, 10, "glitch_wait_entry", n);
    repeat (2) step();
    LOCKED = 1'b1; repeat (4) step();
    LOCKED = 1'b0; step();
    LOCKED = 1'b1;
    wait_sig(0, 1'b1, 30, "glitch_dcm_rst", n);
    chk("glitch_retry", RETRY_CNT, 3'd1);
    wait_sig(1, 1'b1, 80, "glitch_relock", n);
    chk("glitch_retry_clr", RETRY_CNT, 3'd0);

    // Lock arriving on the timeout cycle wins
    LOCKED = 1'b0;
    RST = 1'b0; step(); RST = 1'b1;
    wait_sig(0, 1'b0, 10, "simul_wait_entry", n);
    repeat (17) step();
    LOCKED = 1'b1;
    repeat (2) step();
    chk("simul_pre_dcm", DCM_RST, 1'b0);
    step();
    chk("simul_dcm", DCM_RST, 1'b0);
    chk("simul_retry", RETRY_CNT, 3'd0);
    wait_sig(1, 1'b1, 40, "simul_ready", n);

    // One cycle later the timeout wins
    LOCKED = 1'b0;
    RST = 1'b0; step(); RST = 1'b1;
    wait_sig(0, 1'b0, 10, "late_wait_entry", n);
    repeat (18) step();
    LOCKED = 1'b1;
    repeat (2) step();
    chk("late_dcm", DCM_RST, 1'b1);
    chk("late_retry", RETRY_CNT, 3'd1);

    // Randomized LOCKED runs with rare resets; the model checker compares every cycle
    run = 0;
    for (int c = 0; c < 2000; c++) begin
      if (run == 0) begin
        LOCKED = ~LOCKED;
        run = LOCKED ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30));
      end
      run--;
      RST = ($urandom_range(0, 299) != 0);
      step();
    end

    RST = 1'b1;
    step();
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcm_reset_sequencer.md
Name: dcm_reset_sequencer

Overview:
- Controller that sequences the clock manager generating CLK_50M/CLK_12M.
- Pulses the DCM reset and waits for LOCKED, with a timeout and bounded retries.
- Holds downstream logic in reset until lock has been stable for a programmed window.
- Runs on the raw board clock and sits beside the DCM wrapper at top level; re-sequences automatically on lock loss.

Parameters:
- RST_HOLD_CYCLES, 3, cycles DCM_RST is held high per attempt (min 1).
- LOCK_TIMEOUT, 2000000, cycles to wait for synchronized LOCKED before retrying (min 2).
- STABLE_CYCLES, 1024, consecutive locked cycles required before release (min 1).
- MAX_RETRIES, 7, failed attempts allowed before FAULT (1..7).

Ports:
- CLK  in  1  board clock (same net as CLKFPGA input of DCM)
- RST  in  1  reset, synchronous, active-low
- LOCKED  in  1  DCM lock flag, asynchronous to CLK
- DCM_RST  out  1  reset to DCM, active-high
- SYS_RST_N  out  1  downstream reset, active-low
- READY  out  1  high while in RUN
- FAULT  out  1  sticky lock-failure flag
- RETRY_CNT  out  3  failed attempts in current sequence

Behaviour:
- All outputs are registered.
- LOCKED passes through a 2-flop synchronizer to lock_s; the FSM uses only lock_s.
- One shared down-counter, width $clog2 of the largest parameter plus 1.
- Reset (RST=0 at posedge):
  - state=RESET_DCM, counter=RST_HOLD_CYCLES-1.
  - DCM_RST=1, SYS_RST_N=0, READY=0, FAULT=0, RETRY_CNT=0, synchronizer flops=0.
  - RST low mid-operation restarts from RESET_DCM on the next edge, from any state including FAULT.
- RESET_DCM:
  - DCM_RST=1 for exactly RST_HOLD_CYCLES cycles.
  - Then WAIT_LOCK, counter=LOCK_TIMEOUT-1, DCM_RST=0.
- WAIT_LOCK:
  - lock_s=1 -> STABILIZE, counter=STABLE_CYCLES-1.
  - Counter reaches 0 with lock_s=0 -> timeout:
    - RETRY_CNT==MAX_RETRIES -> FAULT.
    - else RETRY_CNT+1 and RESET_DCM.
  - Lock and timeout in the same cycle: lock wins.
- STABILIZE:
  - lock_s=0 before the count completes -> treated as a failed attempt (same retry/FAULT rule as timeout).
  - lock_s=1 while counter=0 -> RUN.
- RUN:
  - SYS_RST_N=1 and READY=1 starting the cycle after entry; RETRY_CNT cleared on entry.
  - lock_s=0 -> RESET_DCM.
  - SYS_RST_N=0 and READY=0 on the same edge that DCM_RST rises.
  - Lock loss in RUN is not counted as a retry.
- FAULT:
  - DCM_RST=1, SYS_RST_N=0, READY=0, FAULT=1.
  - RETRY_CNT holds its value; exit only via RST.
- Latency: LOCKED rise to SYS_RST_N rise = 2 (sync) + STABLE_CYCLES + 1 cycles.
- SYS_RST_N never rises while DCM_RST=1.
- READY==SYS_RST_N at all times.

Optional Feature:
- Macro DCM_SEQ_LOSS_CNT_EN.
- When defined:
  - Adds output LOSS_CNT[7:0]: count of RUN->RESET_DCM lock-loss events, saturating at 255, cleared only by RST.
  - Adds output LOSS_PULSE: 1-cycle high on each lock-loss event.
- When undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package dcm_seq_pkg:
  - State encoding constants: RESET_DCM=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4, 3-bit.
  - Counter-width function/constant.
- One sub-module: sync_2ff (2-flop single-bit synchronizer, reset value 0), instantiated for LOCKED.

Test Plan (RST_HOLD_CYCLES=3, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2):
- Normal lock:
  - Stimulus: release RST, raise LOCKED 5 cycles after DCM_RST falls.
  - Required: DCM_RST high exactly 3 cycles; SYS_RST_N/READY rise 2+8+1=11 cycles after LOCKED; RETRY_CNT=0.
- Timeout retries:
  - Stimulus: LOCKED held 0.
  - Required: DCM_RST pulses 3 times (RETRY_CNT 0->1->2); FAULT=1 after the third 20-cycle timeout; FAULT stays 1 until RST=0, then clears on the next edge.
- Glitch in STABILIZE:
  - Stimulus: LOCKED high 4 cycles, low 1 cycle.
  - Required: return to RESET_DCM, RETRY_CNT=1; a subsequent clean lock gives READY=1 and RETRY_CNT=0.
- Lock loss in RUN:
  - Stimulus: drop LOCKED.
  - Required: 3 cycles later SYS_RST_N=0 and DCM_RST=1 on the same edge; RETRY_CNT unchanged at 0.
  - With DCM_SEQ_LOSS_CNT_EN: LOSS_CNT=1 and one LOSS_PULSE.
- Simultaneous lock/timeout:
  - Stimulus: lock_s rises on the cycle the counter hits 0.
  - Required: enter STABILIZE, no retry increment.
- Mid-run reset:
  - Stimulus: RST=0 for 1 cycle while in RUN.
  - Required: next edge DCM_RST=1, SYS_RST_N=0, READY=0, FAULT=0, RETRY_CNT=0.
